lane_dropper: RTL

Parametrised single-lane note dropper for the rhythm game. It schedules a configurable number of notes on one lane. Notes fall at a configurable speed, and key presses are judged against a two-tier hit window (perfect/good). The block emits per-note positions to the renderer and judgement pulses plus a running score to the scoreboard. One instance exists per lane and sits between the keyboard keycode registers and the sprite/colour mapper.

---
 rtl/dropper_pkg.sv | 34 +++
 rtl/key_edge_detect.sv | 29 ++
 rtl/lane_dropper.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dropper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dropper_pkg
// Description : Shared types and constants for the lane_dropper note lane.
// Revision    : 1.0 - initial release
// ============================================================================
package dropper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    GOOD    = 2'd1,
    PERFECT = 2'd2,
    MISS    = 2'd3
  } judge_t;

  localparam logic [7:0] KEY_START      = 8'h2c;
  localparam logic [7:0] KEY_RESTART    = 8'h01;
  localparam logic [1:0] POINTS_GOOD    = 2'd1;
  localparam logic [1:0] POINTS_PERFECT = 2'd2;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : key_edge_detect
// Description : Remembers last frame's key-present bit; gives level and rise.
// Revision    : 1.0 - initial release
// ============================================================================
module key_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic pressed_o,
  output logic rose_o
);

  logic key_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q <= 1'b0;
    end else begin
      key_q <= key_i;
    end
  end

  assign pressed_o = key_i;
  assign rose_o    = key_i & ~key_q;

endmodule
`default_nettype wire

// File: rtl/lane_dropper.sv
`default_nettype none
// ============================================================================
// Module      : lane_dropper
// Description : Single-lane falling-note scheduler with perfect/good judging.
//               LANE_DROPPER_EDGE_EN selects rising-edge key presses.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_dropper
  import dropper_pkg::*;
#(
  parameter logic [9:0]  LANE_X      = 10'd220,
  parameter logic [7:0]  LANE_KEY    = 8'h16,
  parameter int          SLOTS       = 4,
  parameter int          TOTAL_NOTES = 8,
  parameter logic [11:0] FIRST_DELAY = 12'd2300,
  parameter logic [11:0] SPAWN_GAP   = 12'd60,
  parameter logic [3:0]  SPEED       = 4'd1,
  parameter logic [9:0]  Y_START     = 10'd100,
  parameter logic [9:0]  NOTE_H      = 10'd40,
  parameter logic [9:0]  HIT_LO      = 10'd340,
  parameter logic [9:0]  PERF_LO     = 10'd370,
  parameter logic [9:0]  Y_MAX       = 10'd400
) (
  input  logic                  frame_clk,
  input  logic                  Reset_n,
  input  logic [7:0]            keycode,
  input  logic [7:0]            keycode_second,
  output logic [9:0]            drop_x,
  output logic [SLOTS*10-1:0]   note_y,
  output logic [SLOTS-1:0]      note_valid,
  output logic                  hit_perfect,
  output logic                  hit_good,
  output logic                  miss,
  output logic [15:0]           score,
  output logic                  done
);

  localparam logic [7:0] TOTAL_Q = 8'(TOTAL_NOTES);

  state_t            state_q, state_d;
  logic [9:0]        y_q [SLOTS];
  logic [9:0]        y_d [SLOTS];
  logic [SLOTS-1:0]  valid_q, valid_d;
  logic [11:0]       cnt_q, cnt_d;
  logic              first_q, first_d;
  logic [7:0]        spawned_q, spawned_d;
  logic [15:0]       score_q, score_d;
  logic              perf_q, perf_d, good_q, good_d, miss_q, miss_d, done_q;

  logic              key_present, key_pressed, key_rose, press_ev;
  logic              unused_edge_out;
  logic [SLOTS-1:0]  best_oh, free_oh;
  logic [9:0]        best_y;
  logic [10:0]       hit_bottom, bottom, moved;
  logic [11:0]       cnt_next, spawn_target;
  judge_t            verdict;

  assign key_present = (keycode == LANE_KEY) || (keycode_second == LANE_KEY);

  key_edge_detect u_key_edge (
    .clk_i     (frame_clk),
    .rst_ni    (Reset_n),
    .key_i     (key_present),
    .pressed_o (key_pressed),
    .rose_o    (key_rose)
  );

`ifdef LANE_DROPPER_EDGE_EN
  assign press_ev        = key_rose;
  assign unused_edge_out = key_pressed;
`else
  assign press_ev        = key_pressed;
  assign unused_edge_out = key_rose;
`endif

  always_comb begin
    state_d      = state_q;
    y_d          = y_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    spawned_d    = spawned_q;
    score_d      = score_q;
    perf_d       = 1'b0;
    good_d       = 1'b0;
    miss_d       = 1'b0;
    best_oh      = '0;
    free_oh      = '0;
    best_y       = '0;
    hit_bottom   = '0;
    bottom       = '0;
    moved        = '0;
    verdict      = NONE;
    cnt_next     = cnt_q + 12'd1;
    spawn_target = first_q ? FIRST_DELAY : SPAWN_GAP;

    case (state_q)
      IDLE: begin
        if (keycode == KEY_START) begin
          state_d   = RUN;
          valid_d   = '0;
          cnt_d     = '0;
          first_d   = 1'b1;
          spawned_d = '0;
          score_d   = '0;
          for (int i = 0; i < SLOTS; i++) y_d[i] = Y_START;
        end
      end

      RUN: begin
        // Judging targets the lowest note on screen (largest y).
        for (int i = 0; i < SLOTS; i++) begin
          if (valid_q[i] && ((best_oh == '0) || (y_q[i] > best_y))) begin
            best_oh    = '0;
            best_oh[i] = 1'b1;
            best_y     = y_q[i];
          end
        end
        hit_bottom = {1'b0, best_y} + {1'b0, NOTE_H};
        if (press_ev && (best_oh != '0)) begin
          if (hit_bottom >= {1'b0, PERF_LO} && hit_bottom < {1'b0, Y_MAX})
            verdict = PERFECT;
          else if (hit_bottom >= {1'b0, HIT_LO} && hit_bottom < {1'b0, PERF_LO})
            verdict = GOOD;
        end
        if (verdict != NONE) begin
          perf_d  = (verdict == PERFECT);
          good_d  = (verdict == GOOD);
          score_d = sat_add16(score_q, (verdict == PERFECT) ? POINTS_PERFECT : POINTS_GOOD);
          for (int i = 0; i < SLOTS; i++) begin
            if (best_oh[i]) begin
              valid_d[i] = 1'b0;
              y_d[i]     = Y_START;
            end
          end
        end

        for (int i = 0; i < SLOTS; i++) begin
          if (valid_d[i]) begin
            bottom = {1'b0, y_q[i]} + {1'b0, NOTE_H};
            moved  = {1'b0, y_q[i]} + {7'd0, SPEED};
            if (bottom >= {1'b0, Y_MAX}) begin
              valid_d[i] = 1'b0;
              y_d[i]     = Y_START;
              miss_d     = 1'b1;
            end else begin
              y_d[i] = moved[10] ? 10'h3FF : moved[9:0];
            end
          end
        end

        if (spawned_q < TOTAL_Q) begin
          for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid_d[i]) begin
              free_oh    = '0;
              free_oh[i] = 1'b1;
            end
          end
          if (cnt_next == spawn_target) begin
            // With no free slot the counter parks so the spawn retries next frame.
            if (free_oh != '0) begin
              cnt_d     = '0;
              first_d   = 1'b0;
              spawned_d = spawned_q + 8'd1;
              for (int i = 0; i < SLOTS; i++) begin
                if (free_oh[i]) begin
                  valid_d[i] = 1'b1;
                  y_d[i]     = Y_START;
                end
              end
            end
          end else begin
            cnt_d = cnt_next;
          end
        end

        if ((spawned_d == TOTAL_Q) && (valid_d == '0)) state_d = DONE;
      end

      DONE: begin
        valid_d = '0;
        for (int i = 0; i < SLOTS; i++) y_d[i] = Y_START;
        if (keycode == KEY_RESTART) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      spawned_q <= '0;
      score_q   <= '0;
      perf_q    <= 1'b0;
      good_q    <= 1'b0;
      miss_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < SLOTS; i++) y_q[i] <= Y_START;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      spawned_q <= spawned_d;
      score_q   <= score_d;
      perf_q    <= perf_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      done_q    <= (state_d == DONE);
      y_q       <= y_d;
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_note_y
    assign note_y[g*10 +: 10] = y_q[g];
  end

  assign drop_x      = LANE_X;
  assign note_valid  = valid_q;
  assign hit_perfect = perf_q;
  assign hit_good    = good_q;
  assign miss        = miss_q;
  assign score       = score_q;
  assign done        = done_q;

endmodule
`default_nettype wire
